// File: rtl/cache_ctrl_if.sv
// CPU and memory buses of the 2-way cache controller.
// cpu_bus_if: start/rwb/address/wdata in; busy/done/hit/rdata/hit_count out.
interface cpu_bus_if;
  logic       start;
  logic       rwb;
  logic [5:0] address;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       hit;
  logic [7:0] rdata;
  logic [7:0] hit_count;

  modport master (
    output start, rwb, address, wdata,
    input  busy, done, hit, rdata, hit_count
  );
  modport slave (
    input  start, rwb, address, wdata,
    output busy, done, hit, rdata, hit_count
  );
endinterface

// mem_bus_if: req/we/addr/wdata toward memory; rdata/ack back.
interface mem_bus_if;
  logic       req;
  logic       we;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );
  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/cache_ctrl.sv
// 2-way x 8-set write-back cache controller, 1-byte lines, LRU.
// Ports: clk, rst_n, cpu (cpu_bus_if.slave), mem (mem_bus_if.master).
module cache_ctrl (
  input  logic      clk,
  input  logic      rst_n,
  cpu_bus_if.slave  cpu,
  mem_bus_if.master mem
);
  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, FILL, RESPOND
  } state_t;

  state_t     state;
  logic       rwb_r;
  logic [5:0] addr_r;
  logic [7:0] wd_r;

  logic       vld   [2][8];
  logic       dirty [2][8];
  logic [2:0] tag   [2][8];
  logic [7:0] data  [2][8];
  logic [7:0] lru;

  logic       vic_r;
  logic       hit_r;
  logic [7:0] rbuf;

  logic       done_q;
  logic       hit_q;
  logic [7:0] rdata_q;
  logic [7:0] hcnt_q;
  logic       req_q;
  logic       we_q;
  logic [5:0] maddr_q;
  logic [7:0] mwd_q;

  logic [2:0] idx;
  logic [2:0] tg;
  logic       h0;
  logic       h1;
  logic       vic;

  assign idx = addr_r[2:0];
  assign tg  = addr_r[5:3];
  assign h0  = vld[0][idx] && (tag[0][idx] == tg);
  assign h1  = vld[1][idx] && (tag[1][idx] == tg);
  // invalid way first, way0 before way1, else LRU
  assign vic = !vld[0][idx] ? 1'b0 :
               !vld[1][idx] ? 1'b1 : lru[idx];

  assign cpu.busy      = (state != IDLE);
  assign cpu.done      = done_q;
  assign cpu.hit       = hit_q;
  assign cpu.rdata     = rdata_q;
  assign cpu.hit_count = hcnt_q;
  assign mem.req       = req_q;
  assign mem.we        = we_q;
  assign mem.addr      = maddr_q;
  assign mem.wdata     = mwd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rwb_r   <= 1'b0;
      addr_r  <= '0;
      wd_r    <= '0;
      lru     <= '0;
      vic_r   <= 1'b0;
      hit_r   <= 1'b0;
      rbuf    <= '0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
      hcnt_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < 8; s++) begin
          vld[w][s]   <= 1'b0;
          dirty[w][s] <= 1'b0;
          tag[w][s]   <= '0;
          data[w][s]  <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      hit_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu.start) begin
            rwb_r  <= cpu.rwb;
            addr_r <= cpu.address;
            wd_r   <= cpu.wdata;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (h0 || h1) begin
            hit_r <= 1'b1;
            if (rwb_r) begin
              rbuf <= data[h1][idx];
            end else begin
              data[h1][idx]  <= wd_r;
              dirty[h1][idx] <= 1'b1;
            end
            lru[idx] <= ~h1;
            state    <= RESPOND;
          end else begin
            hit_r <= 1'b0;
            vic_r <= vic;
            req_q <= 1'b1;
            if (vld[vic][idx] && dirty[vic][idx]) begin
              we_q    <= 1'b1;
              maddr_q <= {tag[vic][idx], idx};
              mwd_q   <= data[vic][idx];
              state   <= WRITEBACK;
            end else begin
              we_q    <= 1'b0;
              maddr_q <= addr_r;
              state   <= FILL;
            end
          end
        end
        WRITEBACK: begin
          // drop req for a cycle; FILL re-issues
          if (mem.ack) begin
            req_q <= 1'b0;
            state <= FILL;
          end
        end
        FILL: begin
          if (!req_q) begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            maddr_q <= addr_r;
          end else if (mem.ack) begin
            req_q             <= 1'b0;
            vld[vic_r][idx]   <= 1'b1;
            tag[vic_r][idx]   <= tg;
            dirty[vic_r][idx] <= ~rwb_r;
            data[vic_r][idx]  <= rwb_r ? mem.rdata : wd_r;
            lru[idx]          <= ~vic_r;
            if (rwb_r) rbuf   <= mem.rdata;
            state             <= RESPOND;
          end
        end
        RESPOND: begin
          done_q <= 1'b1;
          hit_q  <= hit_r;
          if (rwb_r) rdata_q <= rbuf;
          if (hit_r && hcnt_q != 8'hFF)
            hcnt_q <= hcnt_q + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: LRU-list cache model,
// memory responder checking write-back/fill traffic.
module tb_cache_ctrl;
  logic clk;
  logic rst_n;

  cpu_bus_if cpu_b ();
  mem_bus_if mem_b ();

  cache_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu   (cpu_b.slave),
    .mem   (mem_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] tag;
    logic [7:0] data;
    bit         dirty;
  } line_t;

  typedef struct {
    bit         hit;
    logic [7:0] rdata;
    logic [7:0] hc;
  } rsp_t;

  typedef struct {
    bit         we;
    logic [5:0] addr;
    logic [7:0] wd;
  } mt_t;

  line_t      ml [8][2];
  int         mn [8];
  logic [7:0] mmem [64];
  logic [7:0] emem [64];
  int         mhc;
  logic [7:0] rd_m;
  rsp_t       rq [$];
  mt_t        mq [$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ack_lat = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) mn[s] = 0;
    mhc  = 0;
    rd_m = 8'h00;
    rq.delete();
    mq.delete();
  endtask

  // set list kept MRU first; full set evicts the tail
  task automatic model_access(input bit rw,
                              input logic [5:0] a,
                              input logic [7:0] wd,
                              output bit h);
    int    s;
    int    f;
    line_t l;
    mt_t   m;
    rsp_t  r;
    s = int'(a[2:0]);
    f = -1;
    for (int i = 0; i < mn[s]; i++)
      if (ml[s][i].tag == a[5:3]) f = i;
    if (f >= 0) begin
      h = 1'b1;
      l = ml[s][f];
      if (rw) rd_m = l.data;
      else begin
        l.data  = wd;
        l.dirty = 1'b1;
      end
      if (f == 1) ml[s][1] = ml[s][0];
      ml[s][0] = l;
      if (mhc < 255) mhc++;
    end else begin
      h = 1'b0;
      if (mn[s] == 2) begin
        l = ml[s][1];
        if (l.dirty) begin
          m.we   = 1'b1;
          m.addr = {l.tag, a[2:0]};
          m.wd   = l.data;
          mq.push_back(m);
          mmem[m.addr] = l.data;
        end
        mn[s] = 1;
      end
      m.we   = 1'b0;
      m.addr = a;
      m.wd   = 8'h00;
      mq.push_back(m);
      l.tag   = a[5:3];
      l.data  = rw ? mmem[a] : wd;
      l.dirty = !rw;
      if (rw) rd_m = l.data;
      ml[s][1] = ml[s][0];
      ml[s][0] = l;
      mn[s]++;
    end
    r.hit   = h;
    r.rdata = rd_m;
    r.hc    = 8'(mhc);
    rq.push_back(r);
  endtask

  // response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !cpu_b.done && cpu_b.hit)
        chk(1'b0, "hit_without_done", 1, 0);
      if (rst_n && cpu_b.done) begin
        done_cnt++;
        done_cyc = cyc;
        if (rq.size() == 0) begin
          chk(1'b0, "unexpected_done", 1, 0);
        end else begin
          e = rq.pop_front();
          chk(cpu_b.hit == e.hit, "hit",
              32'(cpu_b.hit), 32'(e.hit));
          chk(cpu_b.rdata == e.rdata, "rdata",
              32'(cpu_b.rdata), 32'(e.rdata));
          chk(cpu_b.hit_count == e.hc, "hit_count",
              32'(cpu_b.hit_count), 32'(e.hc));
        end
      end
    end
  end

  // memory responder
  initial begin
    bit         active;
    bit         ackd;
    bit         stable;
    int         cnt;
    int         lat;
    mt_t        e;
    mt_t        s;
    active = 0;
    ackd   = 0;
    stable = 1;
    cnt    = 0;
    lat    = 1;
    mem_b.ack   = 1'b0;
    mem_b.rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active    = 0;
        ackd      = 0;
        mem_b.ack = 1'b0;
      end else begin
        if (ackd) begin
          chk(mem_b.req == 1'b0, "req_drop_after_ack",
              32'(mem_b.req), 0);
          chk(stable, "mem_stable", 32'(stable), 1);
          active = 0;
          ackd   = 0;
        end
        mem_b.ack = 1'b0;
        if (active) begin
          if (!mem_b.req || mem_b.we != s.we ||
              mem_b.addr != s.addr ||
              (s.we && mem_b.wdata != s.wd))
            stable = 0;
          cnt++;
        end else if (mem_b.req) begin
          s.we   = mem_b.we;
          s.addr = mem_b.addr;
          s.wd   = mem_b.wdata;
          if (mq.size() == 0) begin
            chk(1'b0, "unexpected_mem_req",
                {25'd0, s.we, s.addr}, 0);
            e = s;
          end else begin
            e = mq.pop_front();
            chk(s.we == e.we && s.addr == e.addr &&
                (!e.we || s.wd == e.wd), "mem_txn",
                {15'd0, s.we, s.addr, 2'd0, s.wd},
                {15'd0, e.we, e.addr, 2'd0, e.wd});
          end
          active = 1;
          stable = 1;
          cnt    = 1;
          lat = (ack_lat > 0) ? ack_lat
                              : int'($urandom_range(1, 4));
        end else if ($urandom_range(0, 7) == 0) begin
          mem_b.ack   = 1'b1;
          mem_b.rdata = 8'($urandom);
        end
        if (active && cnt == lat) begin
          mem_b.ack   = 1'b1;
          mem_b.rdata = emem[s.addr];
          if (s.we) emem[s.addr] = s.wd;
          ackd = 1;
        end
      end
    end
  end

  // caller is at negedge+1; returns at negedge+1
  task automatic do_op(input bit rw, input logic [5:0] a,
                       input logic [7:0] wd, input bit junk,
                       input bit wait_done);
    bit h;
    int d0;
    int st;
    int t;
    t = 0;
    while (cpu_b.busy && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    model_access(rw, a, wd, h);
    cpu_b.start   = 1'b1;
    cpu_b.rwb     = rw;
    cpu_b.address = a;
    cpu_b.wdata   = wd;
    d0 = done_cnt;
    st = cyc;
    @(negedge clk); #1;
    cpu_b.start   = 1'b0;
    cpu_b.address = 6'($urandom);
    cpu_b.wdata   = 8'($urandom);
    if (wait_done) begin
      t = 0;
      while (done_cnt == d0 && t < 300) begin
        if (junk && cpu_b.busy &&
            $urandom_range(0, 2) == 0) begin
          cpu_b.start   = 1'b1;
          cpu_b.rwb     = 1'($urandom);
          cpu_b.address = 6'($urandom);
        end
        @(negedge clk); #1;
        cpu_b.start = 1'b0;
        t++;
      end
      if (done_cnt == d0)
        chk(1'b0, "done_timeout", 32'(t), 0);
      else if (h)
        chk(done_cyc - st == 3, "hit_latency",
            32'(done_cyc - st - 1), 2);
    end
  endtask

  initial begin
    int t;
    rst_n         = 1'b0;
    cpu_b.start   = 1'b0;
    cpu_b.rwb     = 1'b1;
    cpu_b.address = 6'h00;
    cpu_b.wdata   = 8'h00;
    for (int i = 0; i < 64; i++) begin
      emem[i] = 8'($urandom);
      mmem[i] = emem[i];
    end
    emem[6'h09] = 8'hA5; mmem[6'h09] = 8'hA5;
    emem[6'h2A] = 8'h77; mmem[6'h2A] = 8'h77;
    model_reset();
    #22;
    chk(cpu_b.busy == 0, "rst_busy", 32'(cpu_b.busy), 0);
    chk(cpu_b.done == 0, "rst_done", 32'(cpu_b.done), 0);
    chk(cpu_b.rdata == 0, "rst_rdata",
        32'(cpu_b.rdata), 0);
    chk(cpu_b.hit_count == 0, "rst_hit_count",
        32'(cpu_b.hit_count), 0);
    chk(mem_b.req == 0, "rst_mem_req", 32'(mem_b.req), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    ack_lat = 3;
    do_op(1'b1, 6'h09, 8'h00, 1'b0, 1'b1);
    ack_lat = 0;
    do_op(1'b1, 6'h09, 8'h00, 1'b0, 1'b1);
    do_op(1'b0, 6'h09, 8'h3C, 1'b0, 1'b1);
    do_op(1'b1, 6'h11, 8'h00, 1'b0, 1'b1);
    do_op(1'b1, 6'h19, 8'h00, 1'b0, 1'b1);
    do_op(1'b0, 6'h2A, 8'h01, 1'b0, 1'b1);
    do_op(1'b1, 6'h2A, 8'h00, 1'b0, 1'b1);

    ack_lat = 4;
    do_op(1'b1, 6'h33, 8'h00, 1'b0, 1'b0);
    t = 0;
    while (!(mem_b.req && !mem_b.we) && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    chk(mem_b.req && !mem_b.we, "fill_seen",
        32'(mem_b.req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk(mem_b.req == 0, "arst_mem_req", 32'(mem_b.req), 0);
    chk(mem_b.addr == 0, "arst_mem_addr",
        32'(mem_b.addr), 0);
    chk(cpu_b.busy == 0, "arst_busy", 32'(cpu_b.busy), 0);
    chk(cpu_b.rdata == 0, "arst_rdata",
        32'(cpu_b.rdata), 0);
    chk(cpu_b.hit_count == 0, "arst_hit_count",
        32'(cpu_b.hit_count), 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    ack_lat = 0;
    do_op(1'b1, 6'h33, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++)
      do_op(1'b1, 6'h33, 8'h00, 1'b0, 1'b1);
    chk(cpu_b.hit_count == 8'hFF, "hit_count_sat",
        32'(cpu_b.hit_count), 32'hFF);

    for (int i = 0; i < 300; i++)
      do_op(1'($urandom),
            {3'($urandom_range(0, 3)), 3'($urandom)},
            8'($urandom), 1'b1, 1'b1);

    repeat (4) @(negedge clk);
    chk(rq.size() == 0, "rsp_queue_empty",
        32'(rq.size()), 0);
    chk(mq.size() == 0, "mem_queue_empty",
        32'(mq.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
